data_memory_ctrl: RTL and testbench

Backing data-memory controller sitting directly downstream of the core's data cache: it consumes the cache's miss/write-back traffic (`MissAddr`, `Data2Memory`, `MemWrite2Memory`) and produces `ReadData` for line fills. Writes are absorbed into a small posted write buffer that drains into a single-port word array. Reads take a programmable latency, and can be forwarded from the write buffer when the address matches a pending write.

---
 rtl/data_memory_ctrl.sv | 151 +++++++++++++++
 tb/tb_data_memory_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - Backing data memory with posted write buffer and programmable read latency.
// Optional macro DMEM_WBUF_FORWARD_EN: reads are forwarded from pending write-buffer entries.
module data_memory_ctrl #(
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 3,
  parameter int WBUF_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemWrite2Memory,
  input  logic        MemRead,
  input  logic [31:0] MissAddr,
  input  logic [31:0] Data2Memory,
  output logic [31:0] ReadData,
  output logic        RdValid,
  output logic        RdReady,
  output logic        WrReady,
  output logic        WBufEmpty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = $clog2(WBUF_DEPTH);
  localparam int CNTW = $clog2(WBUF_DEPTH + 1);
  localparam int LW   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [PW-1:0]   head_q, tail_q;
  logic [CNTW-1:0] count_q;

  logic [AW-1:0]   wb_idx_q  [WBUF_DEPTH];
  logic [31:0]     wb_data_q [WBUF_DEPTH];
  logic [31:0]     mem_q     [DEPTH];

  logic [AW-1:0]   widx;
  logic            push, pop, rd_acc;
  logic            fwd_hit;
  logic [31:0]     fwd_data;
  logic            unused_addr_bits;

  assign widx             = MissAddr[AW+1:2];
  assign unused_addr_bits = ^{MissAddr[31:AW+2], MissAddr[1:0]};

  assign WrReady   = (count_q < CNTW'(WBUF_DEPTH));
  assign WBufEmpty = (count_q == '0);
  assign RdValid   = (state_q == RD_RESP);
  assign ReadData  = rdata_q;

  assign push   = MemWrite2Memory & WrReady;
  // The array is frozen while a read waits, so its contents stay as of the accept edge.
  assign pop    = ~WBufEmpty & (state_q != RD_WAIT) & ~Reset;
  assign rd_acc = MemRead & RdReady;

`ifdef DMEM_WBUF_FORWARD_EN
  assign RdReady = (state_q == IDLE);

  // Oldest-to-youngest scan so the youngest match wins; a same-edge write is youngest of all.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if (CNTW'(k) < count_q && wb_idx_q[head_q + PW'(k)] == widx) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[head_q + PW'(k)];
      end
    end
    if (push) begin
      fwd_hit  = 1'b1;
      fwd_data = Data2Memory;
    end
  end
`else
  assign RdReady  = (state_q == IDLE) & WBufEmpty & ~MemWrite2Memory;
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    rd_idx_d = rd_idx_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (rd_acc) begin
          rd_idx_d = widx;
          if (fwd_hit) begin
            rdata_d = fwd_data;
            state_d = RD_RESP;
          end else if (RD_LATENCY == 1) begin
            rdata_d = mem_q[widx];
            state_d = RD_RESP;
          end else begin
            lat_d   = LW'(RD_LATENCY - 1);
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (lat_q == '0) begin
          rdata_d = mem_q[rd_idx_q];
          state_d = RD_RESP;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      RD_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      rd_idx_q <= '0;
      rdata_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      rd_idx_q <= rd_idx_d;
      rdata_q  <= rdata_d;
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      wb_idx_q[tail_q]  <= widx;
      wb_data_q[tail_q] <= Data2Memory;
    end
  end

  always_ff @(posedge CLK) begin
    if (pop) mem_q[wb_idx_q[head_q]] <= wb_data_q[head_q];
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - Scoreboard bench for data_memory_ctrl (default and long-latency instances).
module tb_data_memory_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        Reset;
  logic        m_wr, m_rd, m_valid, m_rrdy, m_wrdy, m_empty;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        s_wr, s_rd, s_valid, s_rrdy, s_wrdy, s_empty;
  logic [31:0] s_addr, s_wdata, s_rdata;

  data_memory_ctrl dut (
    .CLK(CLK), .Reset(Reset), .MemWrite2Memory(m_wr), .MemRead(m_rd),
    .MissAddr(m_addr), .Data2Memory(m_wdata), .ReadData(m_rdata),
    .RdValid(m_valid), .RdReady(m_rrdy), .WrReady(m_wrdy), .WBufEmpty(m_empty)
  );

  data_memory_ctrl #(.RD_LATENCY(6)) dut_slow (
    .CLK(CLK), .Reset(Reset), .MemWrite2Memory(s_wr), .MemRead(s_rd),
    .MissAddr(s_addr), .Data2Memory(s_wdata), .ReadData(s_rdata),
    .RdValid(s_valid), .RdReady(s_rrdy), .WrReady(s_wrdy), .WBufEmpty(s_empty)
  );

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_m[$];
  exp_t exp_s[$];
  exp_t em, es;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  always @(negedge CLK) begin
    if (m_valid === 1'b1) begin
      if (exp_m.size() == 0) begin
        timeout("m_unexpected_rdvalid");
      end else begin
        em = exp_m.pop_front();
        check("m_rdata", m_rdata, em.data);
        check("m_latency", cyc - em.acc, em.lat);
      end
    end
  end

  always @(negedge CLK) begin
    if (s_valid === 1'b1) begin
      if (exp_s.size() == 0) begin
        timeout("s_unexpected_rdvalid");
      end else begin
        es = exp_s.pop_front();
        check("s_rdata", s_rdata, es.data);
        check("s_latency", cyc - es.acc, es.lat);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input bit s, input logic [31:0] a, input logic [31:0] d);
    int t;
    t = 0;
    if (s) begin s_wr = 1; s_addr = a; s_wdata = d; end
    else   begin m_wr = 1; m_addr = a; m_wdata = d; end
    @(negedge CLK);
    while (!(s ? s_wrdy : m_wrdy) && t < 50) begin t++; @(negedge CLK); end
    if (t >= 50) timeout("write_accept");
    @(posedge CLK); #1;
    if (s) s_wr = 0; else m_wr = 0;
  endtask

  task automatic do_read(input bit s, input logic [31:0] a, input logic [31:0] d, input int lat);
    int t;
    t = 0;
    if (s) begin s_rd = 1; s_addr = a; end
    else   begin m_rd = 1; m_addr = a; end
    @(negedge CLK);
    while (!(s ? s_rrdy : m_rrdy) && t < 50) begin t++; @(negedge CLK); end
    if (t >= 50) timeout("read_accept");
    @(posedge CLK); #1;
    if (s) begin s_rd = 0; exp_s.push_back('{d, lat, cyc}); end
    else   begin m_rd = 0; exp_m.push_back('{d, lat, cyc}); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int t, acc;
    bit seen;
    Reset = 1;
    m_wr = 0; m_rd = 0; m_addr = '0; m_wdata = '0;
    s_wr = 0; s_rd = 0; s_addr = '0; s_wdata = '0;
    repeat (3) @(posedge CLK);
    #1 Reset = 0;

    @(negedge CLK);
    check("init_rdvalid", m_valid, 0);
    check("init_rdready", m_rrdy, 1);
    check("init_wbufempty", m_empty, 1);
    @(posedge CLK); #1;

    // Reset while a read sits in RD_WAIT: no RdValid may follow.
    m_rd = 1; m_addr = 32'h0;
    @(negedge CLK);
    check("rst_read_accept_ready", m_rrdy, 1);
    @(posedge CLK); #1;
    m_rd = 0;
    @(negedge CLK);
    check("rst_in_rdwait_rdready", m_rrdy, 0);
    #4 Reset = 1;
    idle(2);
    Reset = 0;
    @(negedge CLK);
    check("rst_rdvalid", m_valid, 0);
    check("rst_readdata", m_rdata, 32'h0);
    check("rst_rdready", m_rrdy, 1);
    check("rst_wrready", m_wrdy, 1);
    check("rst_wbufempty", m_empty, 1);
    @(posedge CLK); #1;

    // Array read latency.
    do_write(0, 32'h40, 32'hDEADBEEF);
    idle(4);
    do_read(0, 32'h40, 32'hDEADBEEF, 3);
    idle(6);

`ifdef DMEM_WBUF_FORWARD_EN
    do_write(0, 32'h40, 32'h11111111);
    m_wr = 1; m_wdata = 32'h22222222; m_rd = 1; m_addr = 32'h40;
    @(negedge CLK);
    check("fwd_wrready", m_wrdy, 1);
    check("fwd_rdready", m_rrdy, 1);
    @(posedge CLK); #1;
    m_wr = 0; m_rd = 0;
    exp_m.push_back('{32'h22222222, 1, cyc});
    idle(4);
    do_read(0, 32'h40, 32'h22222222, 3);
    idle(6);
`else
    do_write(0, 32'h80, 32'hA5A50080);
    m_rd = 1; m_addr = 32'h80;
    @(negedge CLK);
    check("off_rdready_blocked", m_rrdy, 0);
    check("off_wbuf_pending", m_empty, 0);
    t = 0;
    while (!m_rrdy && t < 50) begin t++; @(negedge CLK); end
    if (t >= 50) timeout("off_read_accept");
    check("off_empty_at_ready", m_empty, 1);
    @(posedge CLK); #1;
    m_rd = 0;
    exp_m.push_back('{32'hA5A50080, 3, cyc});
    idle(6);
    do_write(0, 32'h40, 32'h11111111);
    do_write(0, 32'h40, 32'h22222222);
    do_read(0, 32'h40, 32'h22222222, 3);
    idle(6);
`endif

    // Wrap-around: 0x400 aliases word 0 with DEPTH=256; byte offset is ignored.
    do_write(0, 32'h400, 32'hCAFE0400);
    idle(4);
    do_read(0, 32'h000, 32'hCAFE0400, 3);
    idle(6);
    do_read(0, 32'h003, 32'hCAFE0400, 3);
    idle(6);

    // Buffer full on the 6-cycle instance: four writes fill the buffer during RD_WAIT.
    do_write(1, 32'h100, 32'h51000100);
    idle(4);
    do_read(1, 32'h100, 32'h51000100, 6);
    acc = 0; seen = 0; t = 0;
    s_wr = 1; s_addr = 32'h200; s_wdata = 32'h50000000;
    while (acc < 5 && t < 60) begin
      @(negedge CLK);
      t++;
      if (s_valid && !seen) begin
        seen = 1;
        check("full_accepts_at_rdresp", acc, 4);
        check("full_wrready_at_rdresp", s_wrdy, 0);
      end
      if (s_wrdy) begin
        @(posedge CLK); #1;
        acc++;
        s_addr  = 32'h200 + 32'(4 * acc);
        s_wdata = 32'h50000000 + 32'(acc);
      end
    end
    s_wr = 0;
    check("full_total_accepts", acc, 5);
    check("full_rdresp_seen", seen, 1);
    t = 0;
    @(negedge CLK);
    while (!s_empty && t < 40) begin t++; @(negedge CLK); end
    check("full_drained_empty", s_empty, 1);
    @(posedge CLK); #1;
    for (int i = 0; i < 5; i++) begin
      do_read(1, 32'h200 + 32'(4 * i), 32'h50000000 + 32'(i), 6);
    end

    idle(12);
    check("m_scoreboard_drained", exp_m.size(), 0);
    check("s_scoreboard_drained", exp_s.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
